conv2d_mc_engine: RTL and testbench
===================================

# conv2d_mc_engine

Multi-channel, signed int8 2-D convolution engine; parametrised successor of the single-channel conv block. It holds an input feature-map buffer and NCH output planes. One input sample per cycle is broadcast to NCH parallel MAC lanes, each lane with its own kernel and bias. Each lane result is requantised (bias, rounding shift, optional ReLU, saturation) and written to its plane. The host loads data and config over the same memory-port style as before, pulses `start`, and waits for `done`.

## Interface
- DSIZE, 1024: bytes in the input buffer and in each output plane; AW = $clog2(DSIZE)
- KSIZE, 5: maximum kernel width/height
- NCH, 2: output channels (MAC lanes)
- ACCW, 24: accumulator/bias width, signed
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- data_width, data_height  in  8 each  input map size W, H
- out_width, out_height  in  8 each  output pixel counts OW, OH, host-computed as (W-KW)/SX+1 and (H-KH)/SY+1
- stride_x, stride_y  in  4 each  SX, SY; 0 is illegal
- kernel_width, kernel_height  in  4 each  KW, KH, 1..KSIZE
- kernel  in  NCH*KSIZE*KSIZE*8  signed taps
  - channel c, tap (kx,ky) at byte c*KSIZE*KSIZE + ky*KSIZE + kx
- bias  in  NCH*ACCW  signed per-channel bias
- shift  in  5  arithmetic right shift, 0..23
- relu_en  in  1  clamp negatives to 0 before saturation
- mi_addr  in  AW  byte address, word write covers mi_addr..mi_addr+3
- mi_data  in  32  little-endian bytes
- mi_wr  in  1  write strobe
- mo_ch  in  $clog2(NCH) (min 1)  output plane select
- mo_addr  in  AW  byte address
- mo_data  out  32  bytes mo_addr..+3 of plane mo_ch; combinational read
- start  in  1  one-cycle request
- busy  out  1  reset 0
- done  out  1  one-cycle pulse; reset 0
- err  out  1  sticky config error; reset 0; cleared by next accepted start

## Operation
- States: IDLE, CALC, DRAIN.
  - IDLE→CALC on start when config is legal.
  - CALC→DRAIN after the last address is issued.
  - DRAIN→IDLE once the final write completes; done pulses on that transition.
- All config inputs, kernel and bias are latched on the accepted start. Later changes to them have no effect on the run.
- start is ignored while busy. mi_wr is ignored while busy, so the DI buffer is stable during a run.
- Illegal config means any of the following:
  - KW or KH is 0 or greater than KSIZE
  - SX or SY is 0
  - OW or OH is 0
  - (OW-1)*SX+KW > W, or (OH-1)*SY+KH > H
  - OW*OH > DSIZE

  On illegal config: err is set, done pulses the next cycle, nothing is written, and state stays IDLE.
- Loop order: kx innermost, then ky, then ox, then oy.
- Input address is (oy*SY+ky)*W + ox*SX+kx.
- Output address is oy*OW+ox (compact, row-major).
- Per lane: products are 8x8 signed to 16 bits, sign-extended to ACCW. The accumulator loads the product at kx=ky=0 and adds it otherwise; accumulator wrap is not detected.
- Post-process per lane:
  - v = acc + bias
  - if shift>0, v = (v + (1<<(shift-1))) >>> shift
  - if relu_en and v<0, v = 0
  - saturate v to [-128,127]
  - write to DO[c][oy*OW+ox]
- DO contents are not reset.

## Timing
- Pipeline:
  - stage 0: address and tap select
  - stage 1: registered DI byte and taps
  - stage 2: accumulate
  - stage 3: post-process and DO write
- N = OW*OH*KW*KH. Take the cycle in which start is sampled as cycle 0.
  - busy rises in cycle 1.
  - The last address is issued in cycle N.
  - The last DO write is at the edge ending cycle N+3.
  - done is high in cycle N+4, and busy falls in the same cycle.
- Back-to-back windows have no bubble; one window takes KW*KH cycles.
- done and start in the same cycle: the start is accepted.
- Reset mid-run: state returns to IDLE; busy, done, err and all counters clear immediately. The partially written DO is left as-is.

## Structure
- Package conv_pkg holds:
  - state enum
  - int8 saturation limits 127 and -128
  - legality-check function
  - address-arithmetic widths
- Sub-module conv_postproc: one lane of bias add, rounding shift, ReLU and saturation, parametrised by ACCW. Instantiated NCH times.
- Counters and the FSM live in the top module.

## Test plan
- 4x4 map holding 1..16, 2x2 kernel of ones, stride 1, OW=OH=3, shift 0, bias 0 → ch0 out[0]=14, out[8]=54; done in cycle 40.
- Same map, 2x2 kernel, stride 2, OW=OH=2 → ch0 plane = 14, 22, 46, 54; done in cycle 20.
- 3x3 map all 127, 3x3 kernel, OW=OH=1:
  - ch0 taps 127 → ch0 out 127 (saturated)
  - ch1 taps -128 → ch1 out -128
  - ch0 again with shift 11 → 71
  - ch1 with relu_en → 0
- NCH=2, ch0 kernel ones, ch1 kernel centre tap 1, bias1=-5, 4x4 ramp map, 3x3 kernel → ch0 out[0]=54, ch1 out[0]=1.
- kernel_width=6 with start → err=1, done in cycle 1, busy never rises, DO unchanged. A following legal start clears err.
- rst_n low in the middle of CALC → busy, done and err read 0. A subsequent start reproduces scenario 1 exactly.

Source files
------------

// File: rtl/conv2d_mc_engine_pkg.sv
// conv2d_mc_engine_pkg: shared FSM encodings, limits, config record and legality check
package conv2d_mc_engine_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;
  localparam int ADDR_W = 20;
  typedef struct packed {
    logic [7:0] w;
    logic [7:0] ow;
    logic [7:0] oh;
    logic [3:0] sx;
    logic [3:0] sy;
    logic [3:0] kw;
    logic [3:0] kh;
    logic [4:0] shift;
    logic       relu;
  } cfg_t;
  function automatic logic cfg_legal(input logic [7:0] w, h, ow, oh,
                                     input logic [3:0] sx, sy, kw, kh,
                                     input int ksize, dsize);
    return kw != '0 && kh != '0 && int'(kw) <= ksize && int'(kh) <= ksize &&
           sx != '0 && sy != '0 && ow != '0 && oh != '0 &&
           (int'(ow) - 1) * int'(sx) + int'(kw) <= int'(w) &&
           (int'(oh) - 1) * int'(sy) + int'(kh) <= int'(h) &&
           int'(ow) * int'(oh) <= dsize;
  endfunction
endpackage

// File: rtl/conv2d_mc_engine_if.sv
// conv2d_mc_engine_if: host memory port and run control of the convolution engine
interface conv2d_mc_engine_if #(
  parameter int DSIZE = 1024,
  parameter int NCH = 2
);
  localparam int AW = $clog2(DSIZE);
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;
  logic [AW-1:0]  mi_addr;
  logic [31:0]    mi_data;
  logic           mi_wr;
  logic [CHW-1:0] mo_ch;
  logic [AW-1:0]  mo_addr;
  logic [31:0]    mo_data;
  logic           start;
  logic           busy;
  logic           done;
  logic           err;
  modport master (output mi_addr, mi_data, mi_wr, mo_ch, mo_addr, start,
                  input mo_data, busy, done, err);
  modport slave (input mi_addr, mi_data, mi_wr, mo_ch, mo_addr, start,
                 output mo_data, busy, done, err);
endinterface

// File: rtl/conv2d_mc_engine_postproc.sv
// conv2d_mc_engine_postproc: one lane of bias add, rounding shift, ReLU and int8 saturation
module conv2d_mc_engine_postproc
  import conv2d_mc_engine_pkg::*;
#(
  parameter int ACCW = 24
) (
  input  logic signed [ACCW-1:0] acc_i,
  input  logic signed [ACCW-1:0] bias_i,
  input  logic [4:0]             shift_i,
  input  logic                   relu_i,
  output logic [7:0]             q_o
);
  localparam logic signed [ACCW+1:0] HI = (ACCW+2)'(SAT_MAX);
  localparam logic signed [ACCW+1:0] LO = (ACCW+2)'(SAT_MIN);
  logic signed [ACCW+1:0] sum_w, rnd_w, shr_w, rl_w;
  // two guard bits keep acc+bias and the rounding offset from wrapping
  always_comb begin
    sum_w = {{2{acc_i[ACCW-1]}}, acc_i} + {{2{bias_i[ACCW-1]}}, bias_i};
    rnd_w = shift_i == 5'd0 ? '0 : {{(ACCW+1){1'b0}}, 1'b1} << (shift_i - 5'd1);
    shr_w = (sum_w + rnd_w) >>> shift_i;
    rl_w = relu_i && shr_w[ACCW+1] ? '0 : shr_w;
    q_o = rl_w > HI ? 8'(SAT_MAX) : rl_w < LO ? 8'(SAT_MIN) : rl_w[7:0];
  end
endmodule

// File: rtl/conv2d_mc_engine.sv
// conv2d_mc_engine: multi-channel int8 2-D convolution, one DI sample per cycle broadcast to NCH MAC lanes
module conv2d_mc_engine
  import conv2d_mc_engine_pkg::*;
#(
  parameter int DSIZE = 1024,
  parameter int KSIZE = 5,
  parameter int NCH = 2,
  parameter int ACCW = 24
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  data_width_i,
  input  logic [7:0]                  data_height_i,
  input  logic [7:0]                  out_width_i,
  input  logic [7:0]                  out_height_i,
  input  logic [3:0]                  stride_x_i,
  input  logic [3:0]                  stride_y_i,
  input  logic [3:0]                  kernel_width_i,
  input  logic [3:0]                  kernel_height_i,
  input  logic [NCH*KSIZE*KSIZE*8-1:0] kernel_i,
  input  logic [NCH*ACCW-1:0]          bias_i,
  input  logic [4:0]                  shift_i,
  input  logic                        relu_en_i,
  conv2d_mc_engine_if.slave           bus
);
  localparam int AW = $clog2(DSIZE);
  localparam int KK = KSIZE * KSIZE;
  logic [1:0] state_q, state_d;
  cfg_t cfg_q;
  logic [NCH*KK*8-1:0] kern_q;
  logic [NCH*ACCW-1:0] bias_q;
  logic [3:0] kx_q, ky_q, kx_d, ky_d;
  logic [7:0] ox_q, oy_q, ox_d, oy_d;
  logic done_q, err_q;
  logic accept, legal, calc, idle;
  logic kx_last, ky_last, ox_last, oy_last, win_last, run_end;
  logic [AW-1:0] rd_addr, wr_addr;
  int tap_idx;
  logic [7:0] di_mem [DSIZE];
  logic [7:0] do_mem [NCH][DSIZE];
  logic s1_vld_q, s1_end_q, s1_first_q, s1_last_q;
  logic [AW-1:0] s1_oa_q;
  logic signed [7:0] s1_byte_q;
  logic signed [7:0] s1_tap_q [NCH];
  logic s2_vld_q, s2_end_q, s2_first_q, s2_last_q;
  logic [AW-1:0] s2_oa_q;
  logic signed [15:0] s2_prod_q [NCH];
  logic s3_wr_q, s3_end_q;
  logic [AW-1:0] s3_oa_q;
  logic signed [ACCW-1:0] acc_q [NCH];
  logic [7:0] pp_w [NCH];
  assign idle = state_q == S_IDLE;
  assign calc = state_q == S_CALC;
  assign accept = idle && bus.start;
  assign legal = cfg_legal(data_width_i, data_height_i, out_width_i, out_height_i,
                           stride_x_i, stride_y_i, kernel_width_i, kernel_height_i, KSIZE, DSIZE);
  assign bus.busy = !idle;
  assign bus.done = done_q;
  assign bus.err = err_q;
  // window walk: kx innermost, then ky, ox, oy
  always_comb begin
    kx_last = kx_q == cfg_q.kw - 4'd1;
    ky_last = ky_q == cfg_q.kh - 4'd1;
    ox_last = ox_q == cfg_q.ow - 8'd1;
    oy_last = oy_q == cfg_q.oh - 8'd1;
    win_last = kx_last && ky_last;
    run_end = win_last && ox_last && oy_last;
    kx_d = kx_last ? '0 : kx_q + 4'd1;
    ky_d = !kx_last ? ky_q : ky_last ? '0 : ky_q + 4'd1;
    ox_d = !win_last ? ox_q : ox_last ? '0 : ox_q + 8'd1;
    oy_d = !(win_last && ox_last) ? oy_q : oy_last ? '0 : oy_q + 8'd1;
    state_d = accept && legal ? S_CALC :
              calc && run_end ? S_DRAIN :
              state_q == S_DRAIN && s3_end_q ? S_IDLE : state_q;
    rd_addr = AW'((ADDR_W'(oy_q) * ADDR_W'(cfg_q.sy) + ADDR_W'(ky_q)) * ADDR_W'(cfg_q.w) +
                  ADDR_W'(ox_q) * ADDR_W'(cfg_q.sx) + ADDR_W'(kx_q));
    wr_addr = AW'(ADDR_W'(oy_q) * ADDR_W'(cfg_q.ow) + ADDR_W'(ox_q));
    tap_idx = int'(ky_q) * KSIZE + int'(kx_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q <= 1'b0;
      err_q <= 1'b0;
      kx_q <= '0;
      ky_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      s1_vld_q <= 1'b0;
      s1_end_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_end_q <= 1'b0;
      s3_wr_q <= 1'b0;
      s3_end_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= (accept && !legal) || (state_q == S_DRAIN && s3_end_q);
      if (accept) err_q <= !legal;
      kx_q <= accept ? '0 : calc ? kx_d : kx_q;
      ky_q <= accept ? '0 : calc ? ky_d : ky_q;
      ox_q <= accept ? '0 : calc ? ox_d : ox_q;
      oy_q <= accept ? '0 : calc ? oy_d : oy_q;
      s1_vld_q <= calc;
      s1_end_q <= calc && run_end;
      s2_vld_q <= s1_vld_q;
      s2_end_q <= s1_end_q;
      s3_wr_q <= s2_vld_q && s2_last_q;
      s3_end_q <= s2_end_q;
    end
  end
  // datapath and buffers carry no reset; control valids above gate every use
  always_ff @(posedge clk) begin
    if (bus.mi_wr && idle)
      for (int i = 0; i < 4; i++) di_mem[bus.mi_addr + AW'(i)] <= bus.mi_data[8*i +: 8];
    if (accept && legal) begin
      cfg_q <= '{w: data_width_i, ow: out_width_i, oh: out_height_i, sx: stride_x_i, sy: stride_y_i,
                 kw: kernel_width_i, kh: kernel_height_i, shift: shift_i, relu: relu_en_i};
      kern_q <= kernel_i;
      bias_q <= bias_i;
    end
    s1_byte_q <= di_mem[rd_addr];
    s1_first_q <= kx_q == '0 && ky_q == '0;
    s1_last_q <= win_last;
    s1_oa_q <= wr_addr;
    s2_first_q <= s1_first_q;
    s2_last_q <= s1_last_q;
    s2_oa_q <= s1_oa_q;
    s3_oa_q <= s2_oa_q;
    for (int c = 0; c < NCH; c++) begin
      s1_tap_q[c] <= kern_q[(c*KK + tap_idx)*8 +: 8];
      s2_prod_q[c] <= 16'(s1_byte_q) * 16'(s1_tap_q[c]);
      if (s2_vld_q) acc_q[c] <= s2_first_q ? ACCW'(s2_prod_q[c]) : acc_q[c] + ACCW'(s2_prod_q[c]);
      if (s3_wr_q) do_mem[c][s3_oa_q] <= pp_w[c];
    end
  end
  for (genvar c = 0; c < NCH; c++) begin : g_pp
    conv2d_mc_engine_postproc #(.ACCW(ACCW)) u_pp (
      .acc_i(acc_q[c]),
      .bias_i(bias_q[c*ACCW +: ACCW]),
      .shift_i(cfg_q.shift),
      .relu_i(cfg_q.relu),
      .q_o(pp_w[c])
    );
  end
  always_comb begin
    bus.mo_data = '0;
    for (int i = 0; i < 4; i++) bus.mo_data[8*i +: 8] = do_mem[bus.mo_ch][bus.mo_addr + AW'(i)];
  end
endmodule

// File: tb/tb_conv2d_mc_engine.sv
// tb_conv2d_mc_engine: table vectors, corner sequences and randomized runs against a plain-arithmetic model
module tb_conv2d_mc_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] dw, dh, ow, oh;
  logic [3:0] sx, sy, kw, kh;
  logic [399:0] kern;
  logic [47:0] bias;
  logic [4:0] sh;
  logic relu;
  conv2d_mc_engine_if #(.DSIZE(1024), .NCH(2)) bus ();
  conv2d_mc_engine #(.DSIZE(1024), .KSIZE(5), .NCH(2), .ACCW(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_width_i(dw), .data_height_i(dh), .out_width_i(ow), .out_height_i(oh),
    .stride_x_i(sx), .stride_y_i(sy), .kernel_width_i(kw), .kernel_height_i(kh),
    .kernel_i(kern), .bias_i(bias), .shift_i(sh), .relu_en_i(relu),
    .bus(bus)
  );
  int checks = 0;
  int failures = 0;
  int m_w, m_h, m_sx, m_sy, m_kw, m_kh, m_sh, m_relu, m_ow, m_oh;
  int di_m [1024];
  int km [2][5][5];
  int bm [2];
  typedef struct {
    int mapv, w, h, sx, sy, kw, kh, k0, k1, b1, sh, relu;
    int ch, addr, exp_v, exp_cyc;
  } vec_t;
  vec_t vecs [12] = '{
    '{0, 4, 4, 1, 1, 2, 2, 1, 1, 0, 0, 0, 0, 0, 14, 40},
    '{0, 4, 4, 1, 1, 2, 2, 1, 1, 0, 0, 0, 0, 8, 54, 40},
    '{0, 4, 4, 2, 2, 2, 2, 1, 1, 0, 0, 0, 0, 0, 14, 20},
    '{0, 4, 4, 2, 2, 2, 2, 1, 1, 0, 0, 0, 0, 1, 22, 20},
    '{0, 4, 4, 2, 2, 2, 2, 1, 1, 0, 0, 0, 0, 2, 46, 20},
    '{0, 4, 4, 2, 2, 2, 2, 1, 1, 0, 0, 0, 0, 3, 54, 20},
    '{127, 3, 3, 1, 1, 3, 3, 127, -128, 0, 0, 0, 0, 0, 127, 13},
    '{127, 3, 3, 1, 1, 3, 3, 127, -128, 0, 0, 0, 1, 0, -128, 13},
    '{127, 3, 3, 1, 1, 3, 3, 127, -128, 0, 11, 0, 0, 0, 71, 13},
    '{127, 3, 3, 1, 1, 3, 3, 127, -128, 0, 0, 1, 1, 0, 0, 13},
    '{0, 4, 4, 1, 1, 3, 3, 1, 999, -5, 0, 0, 0, 0, 54, 40},
    '{0, 4, 4, 1, 1, 3, 3, 1, 999, -5, 0, 0, 1, 0, 1, 40}
  };

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int model_px(input int c, input int ox, input int oy);
    longint acc = 0;
    longint v;
    for (int y = 0; y < m_kh; y++)
      for (int x = 0; x < m_kw; x++)
        acc += longint'(di_m[(oy*m_sy + y)*m_w + ox*m_sx + x]) * longint'(km[c][y][x]);
    v = acc + longint'(bm[c]);
    if (m_sh > 0) v = (v + (64'sd1 <<< (m_sh - 1))) >>> m_sh;
    if (m_relu != 0 && v < 0) v = 0;
    return v > 127 ? 127 : v < -128 ? -128 : int'(v);
  endfunction

  task automatic load_map(input int n);
    for (int a = 0; a < n; a += 4) begin
      bus.mi_addr = 10'(a);
      bus.mi_data = {8'(di_m[a+3]), 8'(di_m[a+2]), 8'(di_m[a+1]), 8'(di_m[a])};
      bus.mi_wr = 1'b1;
      @(posedge clk); #1;
    end
    bus.mi_wr = 1'b0;
  endtask

  task automatic set_inputs();
    dw = 8'(m_w); dh = 8'(m_h); ow = 8'(m_ow); oh = 8'(m_oh);
    sx = 4'(m_sx); sy = 4'(m_sy); kw = 4'(m_kw); kh = 4'(m_kh);
    sh = 5'(m_sh); relu = 1'(m_relu);
    for (int c = 0; c < 2; c++) begin
      bias[c*24 +: 24] = 24'(bm[c]);
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++) kern[(c*25 + y*5 + x)*8 +: 8] = 8'(km[c][y][x]);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!bus.done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      bus.mi_wr = 1'b0;
    end
  endtask

  // scramble=1 disturbs every config input and attempts a DI write once the run is under way
  task automatic run(input bit scramble, output int cyc);
    set_inputs();
    pulse_start();
    if (scramble) begin
      for (int i = 0; i < 50; i++) kern[i*8 +: 8] = 8'($urandom);
      bias = 48'({$urandom, $urandom});
      sh = 5'($urandom);
      relu = ~relu;
      dw = dw + 8'd1;
      bus.mi_addr = '0;
      bus.mi_data = $urandom;
      bus.mi_wr = 1'b1;
    end
    wait_done(cyc);
    bus.mi_wr = 1'b0;
  endtask

  task automatic rd_byte(input int ch, input int addr, output int v);
    bus.mo_ch = 1'(ch);
    bus.mo_addr = 10'(addr);
    #1;
    v = int'($signed(bus.mo_data[7:0]));
  endtask

  task automatic setup(input int mapv, w, h, sxv, syv, kwv, khv, k0, k1, b1, shv, rl);
    m_w = w; m_h = h; m_sx = sxv; m_sy = syv; m_kw = kwv; m_kh = khv;
    m_sh = shv; m_relu = rl;
    m_ow = (w - kwv) / sxv + 1;
    m_oh = (h - khv) / syv + 1;
    for (int i = 0; i < w*h; i++) di_m[i] = mapv == 0 ? i + 1 : mapv;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        km[0][y][x] = (y < khv && x < kwv) ? k0 : 0;
        km[1][y][x] = !(y < khv && x < kwv) ? 0 :
                      k1 != 999 ? k1 : (y == khv/2 && x == kwv/2) ? 1 : 0;
      end
    bm[0] = 0;
    bm[1] = b1;
    load_map(w*h);
  endtask

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  initial begin
    int cyc, v, busy_seen;
    bus.mi_addr = '0; bus.mi_data = '0; bus.mi_wr = 1'b0;
    bus.mo_ch = '0; bus.mo_addr = '0; bus.start = 1'b0;
    dw = '0; dh = '0; ow = '0; oh = '0; sx = '0; sy = '0; kw = '0; kh = '0;
    kern = '0; bias = '0; sh = '0; relu = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_err", int'(bus.err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      setup(vecs[i].mapv, vecs[i].w, vecs[i].h, vecs[i].sx, vecs[i].sy, vecs[i].kw, vecs[i].kh,
            vecs[i].k0, vecs[i].k1, vecs[i].b1, vecs[i].sh, vecs[i].relu);
      run(1'b0, cyc);
      check($sformatf("vec%0d_done_cycle", i), cyc, vecs[i].exp_cyc);
      rd_byte(vecs[i].ch, vecs[i].addr, v);
      check($sformatf("vec%0d_value", i), v, vecs[i].exp_v);
    end

    // start in the same cycle as done is accepted
    setup(0, 4, 4, 2, 2, 2, 2, 1, 1, 0, 0, 0);
    run(1'b0, cyc);
    check("b2b_first_done", cyc, 20);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_busy", int'(bus.busy), 1);
    wait_done(cyc);
    check("b2b_second_done", cyc, 20);
    rd_byte(0, 3, v);
    check("b2b_out3", v, 54);

    // illegal kernel width: immediate done, sticky err, no writes
    set_inputs();
    kw = 4'd6;
    pulse_start();
    check("err_done", int'(bus.done), 1);
    check("err_err", int'(bus.err), 1);
    check("err_busy", int'(bus.busy), 0);
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      busy_seen |= int'(bus.busy);
    end
    check("err_busy_never", busy_seen, 0);
    check("err_sticky", int'(bus.err), 1);
    rd_byte(0, 0, v);
    check("err_do_unchanged", v, model_px(0, 0, 0));
    run(1'b0, cyc);
    check("err_clear_done", cyc, 20);
    check("err_cleared", int'(bus.err), 0);

    // reset mid-run
    setup(0, 4, 4, 1, 1, 2, 2, 1, 1, 0, 0, 0);
    set_inputs();
    sx = 4'd0;
    pulse_start();
    check("rst_pre_err", int'(bus.err), 1);
    set_inputs();
    pulse_start();
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("rst_mid_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #2;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(1'b0, cyc);
    check("rst_rerun_done", cyc, 40);
    rd_byte(0, 0, v);
    check("rst_rerun_out0", v, 14);
    rd_byte(0, 8, v);
    check("rst_rerun_out8", v, 54);

    // randomized maps and kernels against the model, inputs disturbed mid-run
    for (int r = 0; r < 8; r++) begin
      m_w = 3 + int'($urandom_range(9));
      m_h = 3 + int'($urandom_range(9));
      m_kw = 1 + int'($urandom_range((m_w < 5 ? m_w : 5) - 1));
      m_kh = 1 + int'($urandom_range((m_h < 5 ? m_h : 5) - 1));
      m_sx = 1 + int'($urandom_range(2));
      m_sy = 1 + int'($urandom_range(2));
      m_ow = (m_w - m_kw) / m_sx + 1;
      m_oh = (m_h - m_kh) / m_sy + 1;
      m_sh = int'($urandom_range(12));
      m_relu = int'($urandom_range(1));
      for (int i = 0; i < m_w*m_h; i++) di_m[i] = rnd8();
      for (int c = 0; c < 2; c++) begin
        bm[c] = int'($urandom_range(10000)) - 5000;
        for (int y = 0; y < 5; y++)
          for (int x = 0; x < 5; x++) km[c][y][x] = rnd8();
      end
      load_map(m_w*m_h);
      run(1'b1, cyc);
      check($sformatf("rnd%0d_done_cycle", r), cyc, m_ow*m_oh*m_kw*m_kh + 4);
      for (int c = 0; c < 2; c++)
        for (int y = 0; y < m_oh; y++)
          for (int x = 0; x < m_ow; x++) begin
            rd_byte(c, y*m_ow + x, v);
            check($sformatf("rnd%0d_ch%0d_px%0d", r, c, y*m_ow + x), v, model_px(c, x, y));
          end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
